// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction prefetch queue.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 8;
  localparam int FETCH_DATA_W  = 8;
  localparam int FETCH_STATS_W = 8;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] data;
    logic [FETCH_ADDR_W-1:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Memory read port plus consumer handshake of the prefetch queue.
// The master modport is the prefetch side; slave is memory/control unit side.
interface fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
);
  logic [ADDR_W-1:0] address;
  logic              mem_clock;
  logic              mem_write;
  logic [DATA_W-1:0] from_mem;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;

  modport master (
    output address, mem_clock, mem_write, instr, instr_addr, instr_valid,
    input  from_mem, instr_ready, redirect, redirect_target
  );

  modport slave (
    input  address, mem_clock, mem_write, instr, instr_addr, instr_valid,
    output from_mem, instr_ready, redirect, redirect_target
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small FIFO of {data, addr} entries with flush; head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic               head_valid,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop_ok;

  assign head_valid = (count != '0);
  assign pop_ok     = pop && head_valid;
  // Masking keeps the head defined while the unreset storage is still X.
  assign head       = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: issues sequential byte reads ahead of the control unit.
// Optional FETCH_QUEUE_STATS_EN adds a saturating discard_count output.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic clock,
  input  logic reset,
`ifdef FETCH_QUEUE_STATS_EN
  output logic [FETCH_STATS_W-1:0] discard_count,
`endif
  fetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_strobe;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              issue;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] rsp_data;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic              head_valid;

  // Reservations count the outstanding read; a same-cycle pop earns no credit.
  assign occupancy  = (CNT_W+1)'(count) + (CNT_W+1)'(inflight);
  assign issue      = !bus.redirect && (occupancy < (CNT_W+1)'(DEPTH));
  assign push       = inflight && !bus.redirect;
  assign pop        = head_valid && bus.instr_ready;
  assign rsp_data   = bus.from_mem;
  assign push_entry = '{data: rsp_data, addr: mem_addr};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc   <= '0;
      mem_addr   <= '0;
      mem_strobe <= 1'b0;
      inflight   <= 1'b0;
    end else if (bus.redirect) begin
      fetch_pc   <= bus.redirect_target;
      mem_strobe <= 1'b0;
      inflight   <= 1'b0;
    end else begin
      mem_strobe <= issue;
      inflight   <= issue;
      if (issue) begin
        mem_addr <= fetch_pc;
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (bus.redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  assign bus.address     = mem_addr;
  assign bus.mem_clock   = mem_strobe;
  assign bus.mem_write   = 1'b0;
  assign bus.instr       = head.data;
  assign bus.instr_addr  = head.addr;
  assign bus.instr_valid = head_valid;

`ifdef FETCH_QUEUE_STATS_EN
  function automatic logic [FETCH_STATS_W-1:0] sat_add(
    input logic [FETCH_STATS_W-1:0] acc,
    input logic [CNT_W:0]           inc
  );
    logic [FETCH_STATS_W:0] sum;
    sum = {1'b0, acc} + (FETCH_STATS_W+1)'(inc);
    return sum[FETCH_STATS_W] ? '1 : sum[FETCH_STATS_W-1:0];
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset)             discard_count <= '0;
    else if (bus.redirect) discard_count <= sat_add(discard_count, occupancy);
  end
`endif

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch stage between the byte-wide memory module and the control unit. It issues sequential instruction reads ahead of the control unit, buffers the returned bytes with their addresses in a small FIFO, and hands them out over a valid/ready handshake. A branch redirect from the control unit flushes the buffer, discards any in-flight read, and restarts fetching at the branch target.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2
- ADDR_W, 8: instruction address width
- DATA_W, 8: instruction width
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- address  out  ADDR_W  memory read address, registered
- mem_clock  out  1  one-cycle read strobe, registered
- mem_write  out  1  tied 0; this block never writes memory
- from_mem  in  DATA_W  read data, valid on the rising edge after the strobe cycle
- instr  out  DATA_W  head-of-queue instruction
- instr_addr  out  ADDR_W  address of `instr`
- instr_valid  out  1  head entry present
- instr_ready  in  1  consumer accepts head
- redirect  in  1  flush and refetch, single-cycle pulse
- redirect_target  in  ADDR_W  new fetch address, sampled when `redirect` is high

## Operation
- State:
  - fetch_pc: next address to request
  - count: FIFO occupancy, 0..DEPTH
  - rd_ptr / wr_ptr: FIFO pointers, mod DEPTH
  - inflight: one read outstanding
- Issue rule: in a cycle with no redirect, and `count + inflight < DEPTH`:
  - `address <= fetch_pc`, `mem_clock <= 1`, `inflight <= 1`, `fetch_pc <= fetch_pc + 1`
  - Otherwise `mem_clock <= 0`.
  - No credit is taken for a same-cycle pop.
- Response: if `inflight` is set at an edge and there is no redirect at that edge:
  - Write `{from_mem, address}` at `wr_ptr`.
  - Increment `count`.
  - Clear `inflight` unless a new read is issued at the same edge.
- Pop: `instr_valid && instr_ready` advances `rd_ptr` and decrements `count`.
  - A simultaneous push and pop leaves `count` unchanged.
- Redirect has highest priority:
  - `count <= 0`, pointers reset to 0, `inflight <= 0`.
  - The pending response is discarded.
  - `fetch_pc <= redirect_target`; no issue in that cycle; a same-cycle pop is ignored.
  - Issue at the target begins on the next edge.
- `fetch_pc` wraps from 2^ADDR_W-1 to 0; this is not an error.
- `instr` and `instr_addr` show the head entry while `instr_valid`. They are don't-care otherwise and must not be X after reset.

## Timing
- Reset values:
  - address 0, mem_clock 0, mem_write 0
  - instr_valid 0, instr 0, instr_addr 0
  - fetch_pc 0, count 0, inflight 0
- First strobe: on the first edge after reset deasserts. Reset asserted mid-operation aborts everything immediately.
- Latency: strobe at edge N, data captured at edge N+1, `instr_valid` high after edge N+1.
- Redirect latency: redirect sampled at edge R, target strobe at edge R+1, target `instr_valid` after edge R+2.
- Throughput: one instruction per cycle sustained when `instr_ready` is held high.
- Full: with `count = DEPTH` (or `DEPTH-1` plus inflight), issuing stops until a pop.
- Empty: `instr_valid = 0`; `instr_ready` is ignored.

## Configuration
- `FETCH_QUEUE_STATS_EN`, when defined:
  - Adds output `discard_count` (8 bits, reset 0).
  - On each redirect it adds `count + inflight` (entries thrown away), saturating at 255.
- When undefined: the port and logic are absent and behaviour is otherwise identical.

## Structure
- Shared package `fetch_pkg` holds:
  - entry typedef `{data, addr}`
  - default width constants ADDR_W/DATA_W
  - stats counter width
- One sub-module: `fetch_fifo` (storage, pointers, count, push/pop/flush). Issue, inflight and redirect control stay in `fetch_queue`.

## Test plan
- Reset release, `instr_ready = 1`, memory byte = address XOR 0xA5:
  - Strobes at 0x00, 0x01, … on consecutive edges.
  - First `instr_valid` shows instr 0xA5 at address 0x00, then one instruction per cycle.
- `instr_ready = 0`, DEPTH = 4:
  - Exactly 4 strobes, then `mem_clock` stays 0.
  - Raising ready for one cycle pops 0x00 and allows exactly one new strobe, at 0x04.
- Redirect to 0x40 while 3 entries are queued and a read is in flight:
  - `instr_valid` is 0 the next cycle.
  - Next strobe is at 0x40 and the stale response is never presented.
  - With `FETCH_QUEUE_STATS_EN`, `discard_count` = 4.
- `fetch_pc` = 0xFE, free-running: strobes 0xFE, 0xFF, 0x00, with matching `instr_addr`.
- Redirect and pop in the same cycle: the pop is ignored, the queue is empty, and the first new instruction comes from the target.
- Reset asserted while 2 entries are queued:
  - All outputs go to reset values asynchronously.
  - Fetching restarts at 0x00 after release.
